// File: rtl/uart_core_param.sv
// uart_core_param -- parametrised full-duplex UART core.
//
// One transmitter and one receiver on a shared clock. Frame: start bit (0),
// DATA_W data bits LSB first, optional parity bit (runtime p_mode), then
// STOP_BITS stop bits (1).
//
// Parameters:
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   p_mode      parity mode: 00 none, 01 even, 10 odd, 11 none
//   tx_data     word to transmit
//   tx_valid    tx_data valid
//   tx_ready    transmitter idle, accepts a word this cycle
//   tx          serial out, idle high
//   rx          serial in, asynchronous to clk
//   rx_data     last received word
//   rx_valid    one-cycle pulse marking new rx_data / error flags
//   p_error     parity mismatch on last received frame
//   stop_error  a stop bit sampled low on last received frame
module uart_core_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        p_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              p_error,
  output logic              stop_error
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // ---------------------------------------------------------------- TX
  tx_state_e         tx_state_q, tx_state_d;
  logic [TMR_W-1:0]  tx_timer_q, tx_timer_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_en_q, tx_par_en_d;
  logic              tx_par_bit_q, tx_par_bit_d;
  logic              tx_q, tx_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_tick;

  assign tx_tick = (tx_timer_q == TMR_LAST);

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_timer_d   = tx_timer_q + TMR_W'(1);
    tx_cnt_d     = tx_cnt_q;
    tx_shift_d   = tx_shift_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_d         = tx_q;
    tx_ready_d   = tx_ready_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_timer_d = '0;
        if (tx_valid) begin
          // Line drops on the accepting edge itself: no added latency.
          tx_state_d   = TX_START;
          tx_d         = 1'b0;
          tx_ready_d   = 1'b0;
          tx_shift_d   = tx_data;
          tx_par_en_d  = (p_mode == 2'b01) || (p_mode == 2'b10);
          tx_par_bit_d = (^tx_data) ^ (p_mode == 2'b10);
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_timer_d = '0;
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_timer_d = '0;
          if (tx_cnt_q == DATA_LAST) begin
            tx_cnt_d = '0;
            if (tx_par_en_q) begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_bit_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            // Next bit is presented from the shifter before it moves.
            tx_cnt_d   = tx_cnt_q + CNT_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_timer_d = '0;
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_timer_d = '0;
          if (tx_cnt_q == STOP_LAST) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_timer_d = '0;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= TX_IDLE;
      tx_timer_q   <= '0;
      tx_cnt_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_q         <= 1'b1;
      tx_ready_q   <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_timer_q   <= tx_timer_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_q         <= tx_d;
      tx_ready_q   <= tx_ready_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;

  // ---------------------------------------------------------------- RX
  logic              rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [TMR_W-1:0]  rx_timer_q, rx_timer_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [1:0]        rx_pmode_q, rx_pmode_d;
  logic              rx_par_bit_q, rx_par_bit_d;
  logic              rx_serr_q, rx_serr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              p_error_q, p_error_d;
  logic              stop_error_q, stop_error_d;
  logic              rx_tick, rx_par_en, rx_odd, rx_serr_now;

  assign rx_tick     = (rx_timer_q == TMR_LAST);
  assign rx_par_en   = (rx_pmode_q == 2'b01) || (rx_pmode_q == 2'b10);
  assign rx_odd      = (rx_pmode_q == 2'b10);
  assign rx_serr_now = rx_serr_q | ~rx_sync2_q;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_timer_d   = rx_timer_q + TMR_W'(1);
    rx_cnt_d     = rx_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_pmode_d   = rx_pmode_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_serr_d    = rx_serr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    p_error_d    = p_error_q;
    stop_error_d = stop_error_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_timer_d = '0;
        // Edge-triggered start: a line held low never re-arms the receiver.
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_pmode_d = p_mode;
          rx_serr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_timer_q == TMR_HALF) begin
          rx_timer_d = '0;
          rx_cnt_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_timer_d = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_W-1:1]};
          if (rx_cnt_q == DATA_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_timer_d   = '0;
          rx_cnt_d     = '0;
          rx_par_bit_d = rx_sync2_q;
          rx_state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_timer_d = '0;
          rx_serr_d  = rx_serr_now;
          if (rx_cnt_q == STOP_LAST) begin
            rx_cnt_d     = '0;
            rx_state_d   = RX_IDLE;
            rx_valid_d   = 1'b1;
            rx_data_d    = rx_shift_q;
            p_error_d    = rx_par_en & (rx_par_bit_q != ((^rx_shift_q) ^ rx_odd));
            stop_error_d = rx_serr_now;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_timer_d = '0;
        rx_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_timer_q   <= '0;
      rx_cnt_q     <= '0;
      rx_shift_q   <= '0;
      rx_pmode_q   <= '0;
      rx_par_bit_q <= 1'b0;
      rx_serr_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      p_error_q    <= 1'b0;
      stop_error_q <= 1'b0;
    end else begin
      rx_sync1_q   <= rx;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_timer_q   <= rx_timer_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_pmode_q   <= rx_pmode_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_serr_q    <= rx_serr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      p_error_q    <= p_error_d;
      stop_error_q <= stop_error_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign p_error    = p_error_q;
  assign stop_error = stop_error_q;

endmodule

// File: tb/tb_uart_core_param.sv
module tb_uart_core_param;

  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1
  logic [1:0] p_mode;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, rx;
  logic [7:0] rx_data;
  logic       rx_valid, p_error, stop_error;
  logic       loop_en, rx_drv;

  assign rx = loop_en ? tx : rx_drv;

  uart_core_param #(.DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .p_mode(p_mode), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .p_error(p_error),
    .stop_error(stop_error)
  );

  // Second instance: DATA_W=5, STOP_BITS=2, permanently looped back
  logic [1:0] p_mode2;
  logic [4:0] tx_data2, rx_data2;
  logic       tx_valid2, tx_ready2, tx2, rx_valid2, p_error2, stop_error2;

  uart_core_param #(.DATA_W(5), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .p_mode(p_mode2), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .rx(tx2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .p_error(p_error2),
    .stop_error(stop_error2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------ behavioural model
  // TX: on acceptance, expand the frame into a per-cycle line level list.
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t exp_q[$];
  logic m_seq [0:127];
  logic m_busy = 1'b0;
  int   m_idx = 0;
  int   m_len = 0;
  int   m_starts = 0;
  int   m_start_cyc = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic build_frame(input logic [7:0] d, input logic [1:0] pm);
    logic bits [0:15];
    int   nb;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
    if (pm == 2'b01) bits[nb++] = ^d;
    if (pm == 2'b10) bits[nb++] = ~(^d);
    bits[nb++] = 1'b1;
    m_len = 0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < int'(C); k++) m_seq[m_len++] = bits[b];
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_idx  = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_idx == m_len - 1) m_busy = 1'b0;
      else m_idx++;
    end else if (tx_valid) begin
      build_frame(tx_data, p_mode);
      m_busy = 1'b1;
      m_idx  = 0;
      m_starts++;
      m_start_cyc = cyc;
      if (loop_en) exp_q.push_back('{d: tx_data, pe: 1'b0, se: 1'b0});
    end
  end

  // ------------------------------------------------ compare process
  logic rx_valid_prev = 1'b0;

  always @(negedge clk) begin
    chk("tx", {31'd0, tx}, {31'd0, m_busy ? m_seq[m_idx] : 1'b1});
    chk("tx_ready", {31'd0, tx_ready}, {31'd0, !m_busy});
    if (rx_valid) begin
      chk("rx_valid_width", {31'd0, rx_valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
        chk("p_error", {31'd0, p_error}, {31'd0, e.pe});
        chk("stop_error", {31'd0, stop_error}, {31'd0, e.se});
      end
    end
    rx_valid_prev = rx_valid;
  end

  // ------------------------------------------------ stimulus helpers
  task automatic wait_tx_idle();
    @(posedge clk); #2;
    for (int i = 0; i < 100 && m_busy; i++) begin
      @(posedge clk); #2;
    end
    if (m_busy) chk("tx_idle_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  task automatic wait_rx_drained(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    chk("rx_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Send one word and pin the DUT line at each mid-bit plus tx_ready low time.
  task automatic tx_frame_check(input string name, input logic [7:0] d, input logic [1:0] pm,
                                input int nbits, input logic [15:0] exp_bits, input int exp_low);
    logic [15:0] bits;
    int          low;
    bits = '0;
    low  = 0;
    wait_tx_idle();
    tx_data  = d;
    p_mode   = pm;
    tx_valid = 1'b1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!tx_ready) low++;
      if (k < nbits * int'(C) && (k % int'(C)) == 1) bits[k / int'(C)] = tx;
    end
    chk({name, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
    chk({name, "_ready_low"}, 32'(low), 32'(exp_low));
    wait_rx_drained(20);
  endtask

  task automatic drive_rx(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = bits[i];
      repeat (C) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ------------------------------------------------ directed sequence
  initial begin
    int s0, c1, c2;
    logic [15:0] bits2;
    int low2;
    logic got2;
    logic [4:0] d2;
    logic pe2, se2;

    p_mode = 2'b01; tx_data = '0; tx_valid = 1'b0;
    loop_en = 1'b1; rx_drv = 1'b1;
    p_mode2 = 2'b00; tx_data2 = '0; tx_valid2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_p_error", {31'd0, p_error}, 32'd0);
    chk("rst_stop_error", {31'd0, stop_error}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Loopback frames: even / odd / none / 11-as-none parity
    tx_frame_check("even_a5", 8'hA5, 2'b01, 11, 16'h054A, 44);
    tx_frame_check("odd_ff",  8'hFF, 2'b10, 11, 16'h07FE, 44);
    tx_frame_check("none_3c", 8'h3C, 2'b00, 10, 16'h0278, 40);
    tx_frame_check("p11_0f",  8'h0F, 2'b11, 10, 16'h021E, 40);

    // Error injection on the pins, even parity
    wait_tx_idle();
    loop_en = 1'b0;
    p_mode  = 2'b01;
    repeat (4) @(posedge clk); #2;
    exp_q.push_back('{d: 8'h81, pe: 1'b1, se: 1'b0});
    drive_rx(16'h0702, 11);
    rx_drv = 1'b1;
    repeat (4) @(posedge clk); #2;
    exp_q.push_back('{d: 8'h81, pe: 1'b0, se: 1'b1});
    drive_rx(16'h0102, 11);
    // Line stays low: no further frame may appear
    repeat (24) @(posedge clk); #2;
    wait_rx_drained(10);
    rx_drv = 1'b1;
    repeat (8) @(posedge clk); #2;

    // False start, then a good frame straight after
    rx_drv = 1'b0;
    @(posedge clk); #2;
    rx_drv = 1'b1;
    repeat (6) @(posedge clk); #2;
    exp_q.push_back('{d: 8'h5A, pe: 1'b0, se: 1'b0});
    drive_rx(16'h04B4, 11);
    rx_drv = 1'b1;
    wait_rx_drained(20);

    // Back-to-back with tx_valid held high
    loop_en = 1'b1;
    wait_tx_idle();
    s0 = m_starts;
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    for (int i = 0; i < 5 && m_starts == s0; i++) begin
      @(posedge clk); #2;
    end
    chk("b2b_first_accept", 32'(m_starts - s0), 32'd1);
    c1 = m_start_cyc;
    tx_data = 8'h22;
    for (int i = 0; i < 60 && m_starts == s0 + 1; i++) begin
      @(posedge clk); #2;
    end
    chk("b2b_second_accept", 32'(m_starts - s0), 32'd2);
    c2 = m_start_cyc;
    tx_valid = 1'b0;
    chk("b2b_start_spacing", 32'(c2 - c1), 32'd45);
    wait_rx_drained(80);

    // Reset during DATA bit 3 of a looped-back frame
    wait_tx_idle();
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    for (int i = 0; i < 40 && m_idx < 17; i++) begin
      @(posedge clk); #2;
    end
    chk("rst_mid_reached_bit3", {31'd0, m_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (3) @(posedge clk); #2;
    reset = 1'b1;
    repeat (60) @(posedge clk); #2;

    // DATA_W=5, STOP_BITS=2 instance, no parity
    bits2 = '0; low2 = 0; got2 = 1'b0; d2 = '0; pe2 = 1'b0; se2 = 1'b0;
    tx_data2  = 5'h15;
    tx_valid2 = 1'b1;
    @(posedge clk); #2;
    tx_valid2 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (!tx_ready2) low2++;
      if (k < 8 * int'(C) && (k % int'(C)) == 1) bits2[k / int'(C)] = tx2;
      if (rx_valid2 && !got2) begin
        got2 = 1'b1; d2 = rx_data2; pe2 = p_error2; se2 = stop_error2;
      end
    end
    chk("w5_bits", {16'd0, bits2}, 32'h00EA);
    chk("w5_ready_low", 32'(low2), 32'd32);
    chk("w5_rx_valid_seen", {31'd0, got2}, 32'd1);
    chk("w5_rx_data", {27'd0, d2}, 32'h15);
    chk("w5_p_error", {31'd0, pe2}, 32'd0);
    chk("w5_stop_error", {31'd0, se2}, 32'd0);

    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
